// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy state type for the FIFO pointer/flag controller.
package fifo_pkg;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AF_LEVEL = 14;
    localparam int DEF_AE_LEVEL = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_state_t;
endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// Producer/consumer handshake plus RAM control and status bundle for fifo_ram_ctrl.
interface fifo_ram_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              push;
    logic              pop;
    logic              clr_err;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clr_err,
        input  ram_we, ram_re, ram_wr_addr, ram_rd_addr, rd_valid, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err,
        output ram_we, ram_re, ram_wr_addr, ram_rd_addr, rd_valid, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr.sv
// Modulo-2**ADDR_W address pointer with increment enable; wraps naturally.
module fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_ram_ctrl.sv
// Pointer/flag controller driving a synchronous dual-port RAM as a FIFO.
//   state      | meaning
//   ST_EMPTY   | count == 0, pops rejected
//   ST_PARTIAL | 0 < count < DEPTH
//   ST_FULL    | count == DEPTH, pointers equal, pushes rejected
module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    fifo_ram_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AF  = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] CNT_AE  = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    occ_state_t        state_q;
    occ_state_t        state_d;
    logic              af_q;
    logic              ae_q;
    logic              ovf_q;
    logic              unf_q;
    logic              rdv_q;
    logic              full;
    logic              empty;

    assign full  = (state_q == ST_FULL);
    assign empty = (state_q == ST_EMPTY);

    // RAM strobes are held off while reset is asserted, even with requests pending.
    assign wr_acc = bus.push & ~full  & ~rst;
    assign rd_acc = bus.pop  & ~empty & ~rst;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_acc) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (count_d == CNT_MAX)  state_d = ST_FULL;
                else if (count_d == '0)  state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (rd_acc) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            af_q    <= (count_d >= CNT_AF);
            ae_q    <= (count_d <= CNT_AE);
            // A new error in the clearing cycle wins over clr_err.
            ovf_q   <= (bus.push & full)  | (ovf_q & ~bus.clr_err);
            unf_q   <= (bus.pop  & empty) | (unf_q & ~bus.clr_err);
            rdv_q   <= rd_acc;
        end
    end

    assign bus.ram_we       = wr_acc;
    assign bus.ram_re       = rd_acc;
    assign bus.ram_wr_addr  = wr_ptr;
    assign bus.ram_rd_addr  = rd_ptr;
    assign bus.rd_valid     = rdv_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
